parity_frame_checker: RTL

- Multi-channel, frame-aware successor to the single running-parity accumulator.
- Per channel, accumulates the XOR parity of every data word in an event frame and closes the frame on a `last` word.
- On close, compares the computed parity against the trailer parity bit received with that word, and reports mismatch and frame length.
- Sits after the input word demux, ahead of the event builder; feeds the error-monitor registers.

---
 rtl/parity_frame_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/parity_frame_checker.sv
// Multi-channel frame parity checker: per-channel XOR accumulation closed by a `last` word,
// reporting parity mismatch, frame length and over-length frames one cycle after close.
module parity_frame_checker #(
    parameter int unsigned DATA_WIDTH = 23,
    parameter int unsigned NCHAN      = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned LEN_W      = 12,
    parameter int unsigned MAX_WORDS  = 2000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  last,
    input  logic                  trailer_parity,
    input  logic                  clear_counts,
    output logic [NCHAN-1:0]      run_parity,
    output logic                  done,
    output logic [CH_W-1:0]       done_chan,
    output logic [LEN_W-1:0]      frame_len,
    output logic                  par_err,
    output logic                  len_err,
    output logic [NCHAN-1:0]      err_sticky,
    output logic [CNT_W-1:0]      err_count
);

    localparam logic             ODD     = (PARITY_ODD != 0);
    localparam logic [LEN_W:0]   MAX_LEN = (LEN_W + 1)'(MAX_WORDS);
    localparam logic [CH_W:0]    NCH     = (CH_W + 1)'(NCHAN);

    logic [NCHAN-1:0] acc_q, acc_d;
    logic [NCHAN-1:0] ovf_q, ovf_d;
    logic [LEN_W-1:0] cnt_q [NCHAN];
    logic [LEN_W-1:0] cnt_d [NCHAN];

    logic             done_q, done_d;
    logic [CH_W-1:0]  done_chan_q, done_chan_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic             par_err_q, par_err_d;
    logic             len_err_q, len_err_d;
    logic [NCHAN-1:0] err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             hit;
    logic             close;
    logic             word_par;
    logic             sel_acc;
    logic             sel_ovf;
    logic [LEN_W-1:0] sel_cnt;
    logic [LEN_W-1:0] cnt_inc;
    logic             len_over;
    logic             calc;

    always_comb begin
        // Words addressed to a channel that does not exist are dropped.
        hit      = valid & ({1'b0, ch_sel} < NCH);
        close    = hit & last;
        word_par = ^data;

        sel_acc = 1'b0;
        sel_ovf = 1'b0;
        sel_cnt = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (ch_sel == CH_W'(c)) begin
                sel_acc = acc_q[c];
                sel_ovf = ovf_q[c];
                sel_cnt = cnt_q[c];
            end
        end

        cnt_inc  = (&sel_cnt) ? sel_cnt : sel_cnt + 1'b1;
        len_over = {1'b0, cnt_inc} > MAX_LEN;
        calc     = sel_acc ^ word_par ^ ODD;

        acc_d = acc_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (hit && (ch_sel == CH_W'(c))) begin
                if (last) begin
                    acc_d[c] = 1'b0;
                    ovf_d[c] = 1'b0;
                    cnt_d[c] = '0;
                end else begin
                    acc_d[c] = acc_q[c] ^ word_par;
                    ovf_d[c] = ovf_q[c] | len_over;
                    cnt_d[c] = cnt_inc;
                end
            end
        end

        done_d      = close;
        done_chan_d = close ? ch_sel : done_chan_q;
        frame_len_d = close ? cnt_inc : frame_len_q;
        par_err_d   = close & (calc != trailer_parity);
        len_err_d   = close & (sel_ovf | len_over);

        // Error bookkeeping lands together with the done pulse; a clear in the same cycle wins.
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (clear_counts) begin
            err_sticky_d = '0;
            err_count_d  = '0;
        end else if (par_err_d | len_err_d) begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                if (ch_sel == CH_W'(c)) begin
                    err_sticky_d[c] = 1'b1;
                end
            end
            if (!(&err_count_q)) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q        <= '0;
            ovf_q        <= '0;
            for (int unsigned c = 0; c < NCHAN; c++) begin
                cnt_q[c] <= '0;
            end
            done_q       <= 1'b0;
            done_chan_q  <= '0;
            frame_len_q  <= '0;
            par_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            err_sticky_q <= '0;
            err_count_q  <= '0;
        end else begin
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            done_chan_q  <= done_chan_d;
            frame_len_q  <= frame_len_d;
            par_err_q    <= par_err_d;
            len_err_q    <= len_err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign run_parity = acc_q;
    assign done       = done_q;
    assign done_chan  = done_chan_q;
    assign frame_len  = frame_len_q;
    assign par_err    = par_err_q;
    assign len_err    = len_err_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule
